// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] AR_LOCK    = 2'b00;
  localparam logic [3:0] AR_CACHE   = 4'b0000;
  localparam logic [2:0] AR_PROT    = 3'b000;

  localparam logic [3:0] I_ID_DEFAULT = 4'd0;
  localparam logic [3:0] D_ID_DEFAULT = 4'd1;

  localparam int unsigned MAX_D_STREAK_DEFAULT = 4;
  localparam int unsigned STREAK_W             = 4;

endpackage

// File: rtl/axi_rd_arbiter_streak_guard.sv
// Winner selection between I and D requesters: D has priority, but after
// MAX_D_STREAK consecutive D grants with I waiting, I is let through once.
module rr_streak_guard
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_fire,
  output logic grant_d,
  output logic grant_i
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Winner decode from current requests and streak count
  always_comb begin
    grant_d = d_req && (!i_req || (streak_q < STREAK_LIMIT));
    grant_i = i_req && !grant_d;
  end

  // Streak only grows while I is actually being held off
  always_comb begin
    streak_d = streak_q;
    if (grant_fire) begin
      if (grant_d && i_req) begin
        streak_d = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak register
  always_ff @(posedge clk) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between instruction and data read requesters,
// one transaction outstanding, return beats routed to the owner.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0]  I_ID         = I_ID_DEFAULT,
  parameter logic [3:0]  D_ID         = D_ID_DEFAULT,
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [7:0]  i_rd_len,
  input  logic [2:0]  i_rd_size,
  output logic        i_rd_addr_ok,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic [7:0]  d_rd_len,
  input  logic [2:0]  d_rd_size,
  output logic        d_rd_addr_ok,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;          // 1 = data side owns the channel
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic        rd_err_q, rd_err_d;

  logic        grant_d, grant_i, grant_fire;
  logic [3:0]  owner_id;
  logic        unused_rresp;

  assign unused_rresp = ^rresp;
  assign grant_fire   = (state_q == ST_IDLE) && (grant_d || grant_i);
  assign owner_id     = owner_q ? D_ID : I_ID;

  rr_streak_guard #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak_guard (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_rd_req),
    .d_req      (d_rd_req),
    .grant_fire (grant_fire),
    .grant_d    (grant_d),
    .grant_i    (grant_i)
  );

  assign arid    = arvalid ? owner_id : 4'd0;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign arlock  = AR_LOCK;
  assign arcache = AR_CACHE;
  assign arprot  = AR_PROT;
  assign rd_err  = rd_err_q;

  // Next-state, request latching and beat routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    rd_err_d     = rd_err_q;
    i_rd_addr_ok = 1'b0;
    d_rd_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    i_ret_valid  = 1'b0;
    i_ret_last   = 1'b0;
    i_ret_data   = '0;
    d_ret_valid  = 1'b0;
    d_ret_last   = 1'b0;
    d_ret_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          owner_d      = grant_d;
          addr_d       = grant_d ? d_rd_addr : i_rd_addr;
          len_d        = grant_d ? d_rd_len  : i_rd_len;
          size_d       = grant_d ? d_rd_size : i_rd_size;
          i_rd_addr_ok = grant_i;
          d_rd_addr_ok = grant_d;
          state_d      = ST_AR;
        end
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) begin
          if (rid == owner_id) begin
            i_ret_valid = !owner_q;
            i_ret_last  = !owner_q && rlast;
            i_ret_data  = owner_q ? 32'h0 : rdata;
            d_ret_valid = owner_q;
            d_ret_last  = owner_q && rlast;
            d_ret_data  = owner_q ? rdata : 32'h0;
            if (rlast) state_d = ST_IDLE;
          end else begin
            // Foreign beat: swallow it, flag it, stay in R even on rlast
            rd_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: stimulus pushes expected grants,
// AR fields and return beats; a negedge monitor pops and compares.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_rd_req, d_rd_req;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic [7:0]  i_rd_len, d_rd_len;
  logic [2:0]  i_rd_size, d_rd_size;
  logic        i_rd_addr_ok, d_rd_addr_ok;
  logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0] i_ret_data, d_ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, rd_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.I_ID(4'd0), .D_ID(4'd1), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len), .i_rd_size(i_rd_size),
    .i_rd_addr_ok(i_rd_addr_ok), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len), .d_rd_size(d_rd_size),
    .d_rd_addr_ok(d_rd_addr_ok), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rd_err(rd_err)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic        side;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic  gq[$];
  ar_t   aq[$];
  beat_t bq[$];
  int    n_checks = 0;
  int    n_err = 0;

  logic  mon_side;
  beat_t mon_beat;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [69:0] ret_vec(input logic side, input logic [31:0] data, input logic last);
    ret_vec = {!side, side, !side && last, side && last,
               side ? 32'h0 : data, side ? data : 32'h0};
  endfunction

  // Monitor: compare whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (!reset) begin
      if (i_rd_addr_ok || d_rd_addr_ok) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {i_rd_addr_ok, d_rd_addr_ok}, 2'b00);
        end else begin
          mon_side = gq.pop_front();
          chk("grant_side", {i_rd_addr_ok, d_rd_addr_ok}, mon_side ? 2'b01 : 2'b10);
        end
      end
      if (arvalid) begin
        if (aq.size() == 0) begin
          chk("unexpected_arvalid", arvalid, 1'b0);
        end else begin
          chk("ar_fields", {arid, araddr, arlen, arsize}, aq[0]);
          if (arready) void'(aq.pop_front());
        end
      end
      if (i_ret_valid || d_ret_valid) begin
        if (bq.size() == 0) begin
          chk("unexpected_beat", {i_ret_valid, d_ret_valid}, 2'b00);
        end else begin
          mon_beat = bq.pop_front();
          chk("ret_beat", {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, i_ret_data, d_ret_data},
              ret_vec(mon_beat.side, mon_beat.data, mon_beat.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    ar_t e;
    e.id = id; e.addr = a; e.len = l; e.size = s;
    aq.push_back(e);
  endtask

  task automatic set_req(input logic side, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    if (side) begin
      d_rd_req = 1'b1; d_rd_addr = a; d_rd_len = l; d_rd_size = s;
    end else begin
      i_rd_req = 1'b1; i_rd_addr = a; i_rd_len = l; i_rd_size = s;
    end
  endtask

  task automatic wait_grant(input logic side, input logic drop);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = side ? d_rd_addr_ok : i_rd_addr_ok;
    end
    if (!seen) chk("grant_timeout", seen, 1'b1);
    tick();
    if (drop) begin
      if (side) d_rd_req = 1'b0;
      else      i_rd_req = 1'b0;
    end
  endtask

  task automatic ar_phase(input int delay);
    int hold;
    hold = 0;
    for (int k = 0; k <= delay; k++) begin
      arready = (k == delay);
      @(negedge clk);
      if (arvalid) hold++;
      tick();
    end
    arready = 1'b0;
    chk("arvalid_hold_cycles", hold, delay + 1);
  endtask

  task automatic r_beats(input logic [3:0] id, input logic owned, input logic side,
                         input int n, input logic [31:0] base, input logic last_on_final);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rid    = id;
      rdata  = base + 32'(k);
      rlast  = last_on_final && (k == n - 1);
      if (owned) begin
        b.side = side; b.data = rdata; b.last = rlast;
        bq.push_back(b);
      end
      @(negedge clk);
      chk("rready_in_r", rready, 1'b1);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_rd_req = 0; i_rd_addr = 0; i_rd_len = 0; i_rd_size = 0;
    d_rd_req = 0; d_rd_addr = 0; d_rd_len = 0; d_rd_size = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    chk("reset_ctrl", {i_rd_addr_ok, d_rd_addr_ok, arvalid, rready, rd_err, i_ret_valid, d_ret_valid}, 7'h0);
    chk("reset_ar_fields", {arid, araddr, arlen, arsize}, 47'h0);
    chk("ar_constants", {arburst, arlock, arcache, arprot}, {2'b01, 2'b00, 4'h0, 3'h0});
    tick();
    reset = 1'b0;

    // Single 16-beat I burst, arready after 2 cycles
    gq.push_back(1'b0);
    exp_ar(4'd0, 32'hBFC0_0000, 8'd15, 3'd2);
    set_req(1'b0, 32'hBFC0_0000, 8'd15, 3'd2);
    wait_grant(1'b0, 1'b1);
    ar_phase(2);
    r_beats(4'd0, 1'b1, 1'b0, 16, 32'hA000_0000, 1'b1);
    @(negedge clk);
    chk("idle_after_i_burst", {arvalid, rready}, 2'b00);
    tick();

    // Both requesting continuously: D,D,D,D,I,D,D,D,D,I
    set_req(1'b0, 32'h0000_1000, 8'd0, 3'd2);
    set_req(1'b1, 32'h0000_2000, 8'd0, 3'd2);
    for (int t = 0; t < 10; t++) begin
      logic sd;
      sd = ((t % 5) != 4);
      gq.push_back(sd);
      exp_ar(sd ? 4'd1 : 4'd0, sd ? 32'h0000_2000 : 32'h0000_1000, 8'd0, 3'd2);
      wait_grant(sd, 1'b0);
      ar_phase(0);
      r_beats(sd ? 4'd1 : 4'd0, 1'b1, sd, 1, 32'h100 * 32'(t), 1'b1);
    end
    i_rd_req = 1'b0;
    d_rd_req = 1'b0;

    // Single-beat D, then immediate re-grant in the IDLE cycle
    gq.push_back(1'b1);
    exp_ar(4'd1, 32'h1FAF_0000, 8'd0, 3'd2);
    set_req(1'b1, 32'h1FAF_0000, 8'd0, 3'd2);
    wait_grant(1'b1, 1'b1);
    ar_phase(0);
    r_beats(4'd1, 1'b1, 1'b1, 1, 32'h5555_0001, 1'b1);
    gq.push_back(1'b1);
    exp_ar(4'd1, 32'h1FAF_0040, 8'd0, 3'd2);
    set_req(1'b1, 32'h1FAF_0040, 8'd0, 3'd2);
    @(negedge clk);
    chk("regrant_next_cycle", d_rd_addr_ok, 1'b1);
    tick();
    d_rd_req = 1'b0;
    ar_phase(0);
    r_beats(4'd1, 1'b1, 1'b1, 1, 32'h5555_0002, 1'b1);

    // Foreign-id beat while D owns the channel
    gq.push_back(1'b1);
    exp_ar(4'd1, 32'h2000_0000, 8'd0, 3'd2);
    set_req(1'b1, 32'h2000_0000, 8'd0, 3'd2);
    wait_grant(1'b1, 1'b1);
    ar_phase(0);
    r_beats(4'd0, 1'b0, 1'b0, 1, 32'hDEAD_0000, 1'b1);
    @(negedge clk);
    chk("rd_err_set_still_in_r", {rd_err, rready}, 2'b11);
    tick();
    r_beats(4'd1, 1'b1, 1'b1, 1, 32'hBEEF_0000, 1'b1);
    @(negedge clk);
    chk("rd_err_sticky_idle", {rd_err, rready}, 2'b10);
    tick();

    // Four D grants with I pending, reset in the middle of the 4th burst
    set_req(1'b0, 32'h3000_0000, 8'd0, 3'd2);
    set_req(1'b1, 32'h4000_0000, 8'd0, 3'd2);
    for (int t = 0; t < 4; t++) begin
      d_rd_len = (t == 3) ? 8'd7 : 8'd0;
      gq.push_back(1'b1);
      exp_ar(4'd1, 32'h4000_0000, d_rd_len, 3'd2);
      wait_grant(1'b1, 1'b0);
      ar_phase(0);
      if (t < 3) r_beats(4'd1, 1'b1, 1'b1, 1, 32'h7000_0000 + 32'(t), 1'b1);
      else       r_beats(4'd1, 1'b1, 1'b1, 3, 32'h7100_0000, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_rd_len = 8'd0;
    gq.push_back(1'b1);
    @(negedge clk);
    chk("post_reset_ctrl", {arvalid, rready, rd_err, i_ret_valid, d_ret_valid}, 5'h0);
    chk("post_reset_streak_d_wins", {i_rd_addr_ok, d_rd_addr_ok}, 2'b01);
    exp_ar(4'd1, 32'h4000_0000, 8'd0, 3'd2);
    tick();
    d_rd_req = 1'b0;
    ar_phase(0);
    r_beats(4'd1, 1'b1, 1'b1, 1, 32'h7200_0000, 1'b1);
    gq.push_back(1'b0);
    exp_ar(4'd0, 32'h3000_0000, 8'd0, 3'd2);
    wait_grant(1'b0, 1'b1);
    ar_phase(0);
    r_beats(4'd0, 1'b1, 1'b0, 1, 32'h7300_0000, 1'b1);

    // D stalled in AR for 10 cycles while I raises its request
    gq.push_back(1'b1);
    exp_ar(4'd1, 32'h5000_0000, 8'd0, 3'd2);
    set_req(1'b1, 32'h5000_0000, 8'd0, 3'd2);
    wait_grant(1'b1, 1'b1);
    set_req(1'b0, 32'h6000_0000, 8'd0, 3'd2);
    ar_phase(10);
    r_beats(4'd1, 1'b1, 1'b1, 1, 32'h8000_0000, 1'b1);
    gq.push_back(1'b0);
    exp_ar(4'd0, 32'h6000_0000, 8'd0, 3'd2);
    wait_grant(1'b0, 1'b1);
    ar_phase(0);
    r_beats(4'd0, 1'b1, 1'b0, 1, 32'h8100_0000, 1'b1);

    repeat (3) tick();
    chk("queues_drained", gq.size() + aq.size() + bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
